// File: rtl/mem_bus_sched.sv
// rtl/mem_bus_sched.sv - byte-serial memory bus scheduler for fetch and load/store traffic (optional MEM_BUS_FAIR_EN)
module mem_bus_sched #(
    parameter logic [1:0] IO_SEL   = 2'b11,
    parameter int         IF_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [31:0] rdata,
    output logic        if_done,
    output logic        lsb_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        owner_lsb_q, owner_lsb_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    // Write: next byte to send. Read: number of bytes already captured.
    logic [2:0]  idx_q, idx_d;
    // A read address was driven in the previous active cycle.
    logic        pend_q, pend_d;
    // rdy as seen in the previous cycle; tells whether mem_din belongs to pend_q.
    logic        rdy_q;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef MEM_BUS_FAIR_EN
    logic        last_lsb_q, last_lsb_d;
`endif

    logic        pick_lsb;
    logic        valid_cap;
    logic [2:0]  cap_n;
    logic [31:0] wr_addr;
    logic        io_stall;

    assign rdata = rdata_q;

    // Arbitration choice, only meaningful in IDLE.
    always_comb begin
        pick_lsb = lsb_req;
`ifdef MEM_BUS_FAIR_EN
        if (lsb_req && if_req && last_lsb_q) begin
            pick_lsb = 1'b0;
        end
`endif
    end

    // Next-state, datapath updates and bus outputs; nothing advances while rdy is low.
    always_comb begin
        state_d     = state_q;
        owner_lsb_d = owner_lsb_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
`ifdef MEM_BUS_FAIR_EN
        last_lsb_d  = last_lsb_q;
`endif
        mem_a       = 32'd0;
        mem_dout    = 8'd0;
        mem_wr      = 1'b0;
        if_done     = 1'b0;
        lsb_done    = 1'b0;
        busy        = (state_q != S_IDLE);
        valid_cap   = pend_q && rdy_q;
        cap_n       = idx_q + {2'b00, valid_cap};
        wr_addr     = base_q + {29'd0, idx_q};
        io_stall    = (wr_addr[17:16] == IO_SEL) && io_buffer_full;

        case (state_q)
            S_IDLE: begin
                if (rdy && !flush) begin
                    idx_d  = 3'd0;
                    pend_d = 1'b0;
                    buf_d  = 32'd0;
                    if (pick_lsb) begin
                        owner_lsb_d = 1'b1;
                        len_d       = lsb_len;
                        base_d      = lsb_addr;
                        wdata_d     = lsb_wdata;
                        state_d     = lsb_wr ? S_WRITE : S_READ;
`ifdef MEM_BUS_FAIR_EN
                        last_lsb_d  = 1'b1;
`endif
                    end else if (if_req) begin
                        owner_lsb_d = 1'b0;
                        len_d       = 3'(IF_BYTES);
                        base_d      = if_addr;
                        wdata_d     = 32'd0;
                        state_d     = S_READ;
`ifdef MEM_BUS_FAIR_EN
                        last_lsb_d  = 1'b0;
`endif
                    end
                end
            end

            S_READ: begin
                // Drive the first byte not yet captured; a byte lost to a stall is re-driven.
                if (cap_n < len_q) begin
                    mem_a = base_q + {29'd0, cap_n};
                end
                if (rdy) begin
                    if (flush) begin
                        state_d = S_IDLE;
                        pend_d  = 1'b0;
                    end else begin
                        if (valid_cap) begin
                            buf_d[{idx_q[1:0], 3'b000} +: 8] = mem_din;
                        end
                        idx_d  = cap_n;
                        pend_d = (cap_n < len_q);
                        if (cap_n == len_q) begin
                            rdata_d = buf_d;
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_WRITE: begin
                // Stores are committed, so a flush does not interrupt them.
                mem_a    = wr_addr;
                mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy && !io_stall;
                if (rdy && !io_stall) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == len_q - 3'd1) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if_done  = rdy && !owner_lsb_q;
                lsb_done = rdy && owner_lsb_q;
                if (rdy) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_lsb_q <= 1'b0;
            len_q       <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            idx_q       <= 3'd0;
            pend_q      <= 1'b0;
            rdy_q       <= 1'b0;
            buf_q       <= 32'd0;
            rdata_q     <= 32'd0;
`ifdef MEM_BUS_FAIR_EN
            last_lsb_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_lsb_q <= owner_lsb_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            rdy_q       <= rdy;
            buf_q       <= buf_d;
            rdata_q     <= rdata_d;
`ifdef MEM_BUS_FAIR_EN
            last_lsb_q  <= last_lsb_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb/tb_mem_bus_sched.sv - directed self-checking bench for mem_bus_sched
module tb_mem_bus_sched;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsb_req, lsb_wr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_addr, lsb_wdata;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [31:0] rdata;
    logic        if_done, lsb_done, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:65535];
    logic [31:0] wr_a [0:63];
    logic [7:0]  wr_d [0:63];
    int          wr_n = 0;

    mem_bus_sched dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .rdata(rdata), .if_done(if_done), .lsb_done(lsb_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered-output memory with one cycle of read latency; writes are logged.
    always @(posedge clk) begin
        mem_din <= mem[mem_a[15:0]];
        if (mem_wr && wr_n < 64) begin
            wr_a[wr_n] <= mem_a;
            wr_d[wr_n] <= mem_dout;
            wr_n <= wr_n + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
        checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if ({busy, if_done, lsb_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, if_done, lsb_done}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++; if (mem_a !== 32'h1000 + k) begin errors++; $display("FAIL fetch_addr%0d: got %h expected %h", k, mem_a, 32'h1000 + k); end
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_wr%0d: got %b expected 0", k, mem_wr); end
        end
        @(negedge clk); #1;
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done: got %b expected 0", if_done); end
        @(negedge clk); #1;
        checks++; if (if_done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b expected 1", if_done); end
        checks++; if (rdata !== 32'h00000013) begin errors++; $display("FAIL fetch_rdata: got %h expected 00000013", rdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy_done: got %b expected 1", busy); end
        if_req = 1'b0;
        @(negedge clk); #1;
        checks++; if ({busy, if_done} !== 2'b00) begin errors++; $display("FAIL fetch_idle: got %b expected 00", {busy, if_done}); end
    endtask

    task automatic test_arbitration();
        bit if_seen = 0;
        bit ls_seen = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1004;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd2; lsb_addr = 32'h2000;
        @(negedge clk); #1;
        checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL arb_lsb_first: got %h expected 00002000", mem_a); end
        @(negedge clk); #1;
        checks++; if (mem_a !== 32'h2001) begin errors++; $display("FAIL arb_lsb_addr1: got %h expected 00002001", mem_a); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({lsb_done, if_done} !== 2'b10) begin errors++; $display("FAIL arb_lsb_done: got %b expected 10", {lsb_done, if_done}); end
        checks++; if (rdata !== 32'h00001234) begin errors++; $display("FAIL arb_lsb_rdata: got %h expected 00001234", rdata); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle: got %b expected 0", busy); end
        @(negedge clk); #1;
`ifdef MEM_BUS_FAIR_EN
        checks++; if (mem_a !== 32'h1004) begin errors++; $display("FAIL arb_second_grant: got %h expected 00001004", mem_a); end
`else
        checks++; if (mem_a !== 32'h2000) begin errors++; $display("FAIL arb_second_grant: got %h expected 00002000", mem_a); end
`endif
        for (int c = 0; c < 30 && !(if_seen && ls_seen); c++) begin
            @(negedge clk); #1;
            if (lsb_done) begin
                ls_seen = 1;
                lsb_req = 1'b0;
                checks++; if (rdata !== 32'h00001234) begin errors++; $display("FAIL arb_lsb2_rdata: got %h expected 00001234", rdata); end
            end
            if (if_done) begin
                if_seen = 1;
                if_req = 1'b0;
                checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL arb_if_rdata: got %h expected 12345678", rdata); end
            end
        end
        checks++; if ({if_seen, ls_seen} !== 2'b11) begin errors++; $display("FAIL arb_both_done: got %b expected 11", {if_seen, ls_seen}); end
        @(negedge clk);
    endtask

    task automatic test_io_stall();
        logic [31:0] w = 32'hDEADBEEF;
        int start;
        start = wr_n;
        @(negedge clk);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd4; lsb_addr = 32'h30000; lsb_wdata = w;
        io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_stall%0d: got %b expected 0", k, mem_wr); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); io_buffer_full = 1'b0; #1;
            checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL io_wr%0d: got %b expected 1", k, mem_wr); end
            checks++; if (mem_dout !== w[8*k +: 8]) begin errors++; $display("FAIL io_byte%0d: got %h expected %h", k, mem_dout, w[8*k +: 8]); end
            checks++; if (mem_a !== 32'h30000 + k) begin errors++; $display("FAIL io_addr%0d: got %h expected %h", k, mem_a, 32'h30000 + k); end
        end
        @(negedge clk); #1;
        checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL io_done: got %b expected 1", lsb_done); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_done_wr: got %b expected 0", mem_wr); end
        lsb_req = 1'b0;
        checks++; if (wr_n - start !== 4) begin errors++; $display("FAIL io_wr_count: got %0d expected 4", wr_n - start); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] r0;
        logic [31:0] w = 32'h11223344;
        bit done_seen = 0;
        int start;
        r0 = rdata;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h1000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); flush = 1'b1; if_req = 1'b0;
        @(negedge clk); flush = 1'b0; #1;
        checks++; if ({busy, if_done} !== 2'b00) begin errors++; $display("FAIL flush_fetch_idle: got %b expected 00", {busy, if_done}); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (if_done) done_seen = 1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL flush_fetch_nodone: got %b expected 0", done_seen); end
        checks++; if (rdata !== r0) begin errors++; $display("FAIL flush_rdata_kept: got %h expected %h", rdata, r0); end
        start = wr_n;
        @(negedge clk);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd4; lsb_addr = 32'h4000; lsb_wdata = w;
        @(negedge clk);
        @(negedge clk); flush = 1'b1; #1;
        checks++; if ({mem_wr, mem_dout} !== {1'b1, 8'h33}) begin errors++; $display("FAIL flush_store_byte1: got %b/%h expected 1/33", mem_wr, mem_dout); end
        @(negedge clk); flush = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL flush_store_done: got %b expected 1", lsb_done); end
        lsb_req = 1'b0;
        checks++; if (wr_n - start !== 4) begin errors++; $display("FAIL flush_store_count: got %0d expected 4", wr_n - start); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_d[start + i] !== w[8*i +: 8]) begin errors++; $display("FAIL flush_store_data%0d: got %h expected %h", i, wr_d[start + i], w[8*i +: 8]); end
        end
        @(negedge clk);
    endtask

    task automatic test_rdy_stall();
        int done_k = -1;
        @(negedge clk);
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd4; lsb_addr = 32'h5000;
        @(negedge clk);
        @(negedge clk); rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); rdy = 1'b1; #1;
        checks++; if (mem_a !== 32'h5000) begin errors++; $display("FAIL rdy_redrive: got %h expected 00005000", mem_a); end
        for (int k = 4; k < 20 && done_k < 0; k++) begin
            @(negedge clk); #1;
            if (lsb_done) begin
                done_k = k;
                lsb_req = 1'b0;
            end
        end
        checks++; if (done_k !== 8) begin errors++; $display("FAIL rdy_done_cycle: got %0d expected 8", done_k); end
        checks++; if (rdata !== 32'hD4C3B2A1) begin errors++; $display("FAIL rdy_rdata: got %h expected d4c3b2a1", rdata); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hA5;
        @(negedge clk);
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 3'd2; lsb_addr = 32'hFFFFFFFF;
        @(negedge clk); #1;
        checks++; if (mem_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_addr0: got %h expected ffffffff", mem_a); end
        @(negedge clk); #1;
        checks++; if (mem_a !== 32'h00000000) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", mem_a); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (lsb_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", lsb_done); end
        checks++; if (rdata !== 32'h0000A55A) begin errors++; $display("FAIL wrap_rdata: got %h expected 0000a55a", rdata); end
        lsb_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        bit done_seen = 0;
        @(negedge clk);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 3'd4; lsb_addr = 32'h6000; lsb_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1; lsb_req = 1'b0; #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rstw_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL rstw_mem_a: got %h expected 0", mem_a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b expected 0", busy); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rstw_rdata: got %h expected 0", rdata); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (lsb_done) done_seen = 1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rstw_nodone: got %b expected 0", done_seen); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1000] = 8'h13;
        mem[16'h1004] = 8'h78; mem[16'h1005] = 8'h56; mem[16'h1006] = 8'h34; mem[16'h1007] = 8'h12;
        mem[16'h2000] = 8'h34; mem[16'h2001] = 8'h12;
        mem[16'h5000] = 8'hA1; mem[16'h5001] = 8'hB2; mem[16'h5002] = 8'hC3; mem[16'h5003] = 8'hD4;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = 3'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        io_buffer_full = 1'b0;
        test_reset();
        test_fetch();
        test_arbitration();
        test_io_stall();
        test_flush();
        test_rdy_stall();
        test_wrap();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
